// File: rtl/bram_msg_reader_pkg.sv
// Shared types and constants for the character-ROM message reader.
package bram_msg_reader_pkg;

    localparam int ROM_AW = 11;
    localparam int ROM_DW = 8;
    localparam int CNT_W  = 12;

    localparam logic [ROM_DW-1:0] DEFAULT_TERMINATOR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/bram_msg_reader.sv
// Walks the character ROM from BASE_ADDR and streams each byte out over
// valid/ready until the terminator byte or the length cap is reached.
module bram_msg_reader
    import bram_msg_reader_pkg::*;
#(
    parameter logic [ROM_AW-1:0] BASE_ADDR  = 11'h000,
    parameter logic [CNT_W-1:0]  MAX_LEN    = 12'd2048,
    parameter logic [ROM_DW-1:0] TERMINATOR = DEFAULT_TERMINATOR,
    parameter logic              LOOP       = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] address,
    input  logic [ROM_DW-1:0] output_char,
    output logic [ROM_DW-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ROM_AW-1:0]   address_q, address_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ROM_DW-1:0]   char_out_q, char_out_d;
    logic                char_valid_q, char_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Register every output plus the FSM, address and emitted-character count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            address_q    <= BASE_ADDR;
            count_q      <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            count_q      <= count_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic: the ROM read is given one FETCH cycle to land, then the
    // byte is inspected in LATCH and either offered downstream or ends the pass.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        count_d      = count_q;
        char_out_d   = char_out_q;
        char_valid_d = char_valid_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                address_d = BASE_ADDR;
                count_d   = '0;
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if ((output_char == TERMINATOR) || (count_q == MAX_LEN)) begin
                    state_d = ST_DONE;
                end else begin
                    char_out_d   = output_char;
                    char_valid_d = 1'b1;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (char_valid_q && char_ready) begin
                    char_valid_d = 1'b0;
                    address_d    = address_q + 1'b1;
                    count_d      = count_q + 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_DONE: begin
                done_d    = 1'b1;
                address_d = BASE_ADDR;
                count_d   = '0;
                state_d   = LOOP ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign address    = address_q;
    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bram_msg_reader.sv
// Bench for bram_msg_reader: five instances with different parameter sets,
// each beside its own registered-output ROM model sharing one ROM image.
module tb_bram_msg_reader;
    import bram_msg_reader_pkg::*;

    localparam int N = 5;

    logic clk = 1'b0;
    logic reset;

    logic        start      [N];
    logic        char_ready [N];
    logic [10:0] addr       [N];
    logic [7:0]  rom_q      [N];
    logic [7:0]  cout       [N];
    logic        cval       [N];
    logic        busy       [N];
    logic        done       [N];

    logic [7:0]  rom [0:2047];

    int baseOf   [N] = '{32'h000, 32'h040, 32'h020, 32'h7FF, 32'h000};
    int maxLenOf [N] = '{2048, 5, 2048, 2, 2048};

    int total = 0;
    int bad   = 0;

    logic [7:0]  got     [$];
    logic [7:0]  exp     [$];
    logic [10:0] gotAddr [$];
    int          hsCycle [$];
    int          firstValid;
    int          doneCycle;
    int          stableViol;
    int          holdCharBad;
    int          holdAddrBad;
    int          maxAddr;
    bit          timedOut;

    // Free-running clock.
    always #5 clk = ~clk;

    // One-cycle registered ROM read per instance, cleared by the shared SSR.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            rom_q[k] <= reset ? 8'h00 : rom[addr[k]];
        end
    end

    bram_msg_reader #(.BASE_ADDR(11'h000), .MAX_LEN(12'd2048), .TERMINATOR(8'hFF), .LOOP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .address(addr[0]), .output_char(rom_q[0]),
        .char_out(cout[0]), .char_valid(cval[0]), .char_ready(char_ready[0]), .busy(busy[0]), .done(done[0]));
    bram_msg_reader #(.BASE_ADDR(11'h040), .MAX_LEN(12'd5), .TERMINATOR(8'hFF), .LOOP(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .address(addr[1]), .output_char(rom_q[1]),
        .char_out(cout[1]), .char_valid(cval[1]), .char_ready(char_ready[1]), .busy(busy[1]), .done(done[1]));
    bram_msg_reader #(.BASE_ADDR(11'h020), .MAX_LEN(12'd2048), .TERMINATOR(8'hFF), .LOOP(1'b0)) dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .address(addr[2]), .output_char(rom_q[2]),
        .char_out(cout[2]), .char_valid(cval[2]), .char_ready(char_ready[2]), .busy(busy[2]), .done(done[2]));
    bram_msg_reader #(.BASE_ADDR(11'h7FF), .MAX_LEN(12'd2), .TERMINATOR(8'hFF), .LOOP(1'b0)) dut3 (
        .clk(clk), .reset(reset), .start(start[3]), .address(addr[3]), .output_char(rom_q[3]),
        .char_out(cout[3]), .char_valid(cval[3]), .char_ready(char_ready[3]), .busy(busy[3]), .done(done[3]));
    bram_msg_reader #(.BASE_ADDR(11'h000), .MAX_LEN(12'd2048), .TERMINATOR(8'hFF), .LOOP(1'b1)) dut4 (
        .clk(clk), .reset(reset), .start(start[4]), .address(addr[4]), .output_char(rom_q[4]),
        .char_out(cout[4]), .char_valid(cval[4]), .char_ready(char_ready[4]), .busy(busy[4]), .done(done[4]));

    // Reference: the message is the ROM walked from the base address, stopping at
    // the terminator or after the length cap, with the address wrapping at 2048.
    function automatic void buildExpected(input int k);
        int a;
        exp.delete();
        a = baseOf[k];
        for (int n = 0; n < maxLenOf[k]; n++) begin
            if (rom[a] == 8'hFF) break;
            exp.push_back(rom[a]);
            a = (a + 1) % 2048;
        end
    endfunction

    function automatic int seqErrors();
        int errs;
        int m;
        errs = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
        m = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < m; i++) begin
            if (got[i] !== exp[i]) errs++;
        end
        return errs;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // Runs one pass on instance k, sampling on falling edges; c=0 is the first
    // falling edge after the rising edge that sampled start.
    task automatic applyStimulus(input int k, input bit doStart, input bit randReady,
                                 input int holdFirst, input int midStartAt, input int budget);
        bit          prevPending;
        logic [7:0]  prevChar;
        int          held;
        got.delete(); gotAddr.delete(); hsCycle.delete();
        firstValid = -1; doneCycle = -1; stableViol = 0; holdCharBad = 0; holdAddrBad = 0;
        maxAddr = 0; timedOut = 1'b0; prevPending = 1'b0; prevChar = 8'h00; held = 0;
        buildExpected(k);
        if (doStart) begin
            @(negedge clk);
            start[k] = 1'b1;
            @(negedge clk);
            start[k] = 1'b0;
        end else begin
            @(negedge clk);
        end
        for (int c = 0; c < budget; c++) begin
            if (done[k]) begin
                doneCycle = c;
                break;
            end
            if (int'(addr[k]) > maxAddr) maxAddr = int'(addr[k]);
            if (cval[k] && firstValid < 0) firstValid = c;
            if (prevPending && (!cval[k] || cout[k] !== prevChar)) stableViol++;
            if (midStartAt >= 0) start[k] = (c == midStartAt);
            if (cval[k] && held < holdFirst) begin
                char_ready[k] = 1'b0;
                held++;
                if (cout[k] !== 8'h41) holdCharBad++;
                if (int'(addr[k]) != baseOf[k]) holdAddrBad++;
            end else begin
                char_ready[k] = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (cval[k] && char_ready[k]) begin
                got.push_back(cout[k]);
                gotAddr.push_back(addr[k]);
                hsCycle.push_back(c);
            end
            prevPending = cval[k] && !char_ready[k];
            prevChar = cout[k];
            @(negedge clk);
        end
        start[k] = 1'b0;
        if (doneCycle < 0) timedOut = 1'b1;
    endtask

    initial begin
        string msgA;
        string msgM;
        int    spacingBad;
        int    lastHs;
        int    accepted;
        int    doneSeen;
        int    busySeen;

        msgA = "ABCDEFGHIJKLMNOPabcdefghijklmno ";
        msgM = "Merry Christmas";
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 254));
        for (int i = 0; i < 32; i++) rom[i] = msgA[i];
        rom[32'h20] = 8'hFF;
        for (int i = 0; i < msgM.len(); i++) rom[32'h40 + i] = msgM[i];
        rom[32'h40 + msgM.len()] = 8'hFF;

        for (int k = 0; k < N; k++) begin
            start[k] = 1'b0;
            char_ready[k] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_addr", int'(addr[0]), 0);
        checkOutput("rst_char_out", int'(cout[0]), 0);
        checkOutput("rst_valid", int'(cval[0]), 0);
        checkOutput("rst_busy", int'(busy[0]), 0);
        checkOutput("rst_done", int'(done[0]), 0);
        checkOutput("rst_addr_7ff", int'(addr[3]), 32'h7FF);

        $display("[TB] basic pass, ready high");
        applyStimulus(0, 1'b1, 1'b0, 0, -1, 400);
        checkOutput("basic_timeout", int'(timedOut), 0);
        checkOutput("basic_len", got.size(), 32);
        checkOutput("basic_seq", seqErrors(), 0);
        checkOutput("basic_first_valid", firstValid, 2);
        spacingBad = 0;
        for (int i = 1; i < hsCycle.size(); i++) if (hsCycle[i] - hsCycle[i-1] != 3) spacingBad++;
        checkOutput("basic_spacing", spacingBad, 0);
        lastHs = (hsCycle.size() > 0) ? hsCycle[hsCycle.size()-1] : -100;
        checkOutput("basic_done_time", doneCycle, lastHs + 4);
        checkOutput("basic_max_addr", int'(maxAddr <= 32'h20), 1);
        @(negedge clk);
        checkOutput("basic_done_pulse", int'(done[0]), 0);
        checkOutput("basic_idle_busy", int'(busy[0]), 0);

        $display("[TB] backpressure with random ready");
        applyStimulus(0, 1'b1, 1'b1, 10, -1, 1500);
        checkOutput("bp_timeout", int'(timedOut), 0);
        checkOutput("bp_hold_char", holdCharBad, 0);
        checkOutput("bp_hold_addr", holdAddrBad, 0);
        checkOutput("bp_stable", stableViol, 0);
        checkOutput("bp_seq", seqErrors(), 0);
        checkOutput("bp_second_char", int'((got.size() > 1) ? got[1] : 8'h00), 32'h42);

        $display("[TB] length cap with start during pass");
        applyStimulus(1, 1'b1, 1'b1, 0, 7, 400);
        checkOutput("cap_timeout", int'(timedOut), 0);
        checkOutput("cap_len", got.size(), 5);
        checkOutput("cap_seq", seqErrors(), 0);
        busySeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy[1] || cval[1]) busySeen++;
        end
        checkOutput("cap_no_restart", busySeen, 0);

        $display("[TB] empty message and address wrap");
        applyStimulus(2, 1'b1, 1'b0, 0, -1, 50);
        checkOutput("empty_len", got.size(), 0);
        checkOutput("empty_no_valid", firstValid, -1);
        checkOutput("empty_done_time", doneCycle, 3);
        applyStimulus(3, 1'b1, 1'b1, 0, -1, 200);
        checkOutput("wrap_timeout", int'(timedOut), 0);
        checkOutput("wrap_seq", seqErrors(), 0);
        checkOutput("wrap_addr0", (gotAddr.size() > 0) ? int'(gotAddr[0]) : -1, 32'h7FF);
        checkOutput("wrap_addr1", (gotAddr.size() > 1) ? int'(gotAddr[1]) : -1, 0);

        $display("[TB] reset during third SEND");
        @(negedge clk);
        start[0] = 1'b1;
        char_ready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        accepted = 0;
        for (int c = 0; c < 60; c++) begin
            if (cval[0]) begin
                if (accepted == 2) begin
                    char_ready[0] = 1'b0;
                    break;
                end
                accepted++;
            end
            @(negedge clk);
        end
        checkOutput("mid_third_char", int'(cout[0]), 32'h43);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_valid", int'(cval[0]), 0);
        checkOutput("mid_busy", int'(busy[0]), 0);
        checkOutput("mid_addr", int'(addr[0]), 0);
        reset = 1'b0;
        doneSeen = 0;
        repeat (6) begin
            if (done[0]) doneSeen++;
            @(negedge clk);
        end
        checkOutput("mid_no_done", doneSeen, 0);
        applyStimulus(0, 1'b1, 1'b1, 0, -1, 1500);
        checkOutput("mid_restart_seq", seqErrors(), 0);

        $display("[TB] looping replay");
        applyStimulus(4, 1'b1, 1'b0, 0, -1, 400);
        checkOutput("loop1_timeout", int'(timedOut), 0);
        checkOutput("loop1_seq", seqErrors(), 0);
        applyStimulus(4, 1'b0, 1'b0, 0, -1, 400);
        checkOutput("loop2_first_valid", firstValid, 1);
        checkOutput("loop2_seq", seqErrors(), 0);
        checkOutput("loop2_timeout", int'(timedOut), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
